// File: rtl/zet_regfile_pkg.sv
// Shared constants and types for the checkpointed 8086-style register file:
// register indices, FLAGS layout and the checkpoint sequencer states.
package zet_regfile_pkg;

  localparam int REG_AX = 0;
  localparam int REG_CX = 1;
  localparam int REG_DX = 2;
  localparam int REG_BX = 3;
  localparam int REG_SP = 4;
  localparam int REG_BP = 5;
  localparam int REG_SI = 6;
  localparam int REG_DI = 7;
  localparam int REG_ES = 8;
  localparam int REG_CS = 9;
  localparam int REG_SS = 10;
  localparam int REG_DS = 11;
  localparam int REG_IP = 15;

  localparam int FLAG_CF = 0;
  localparam int FLAG_PF = 2;
  localparam int FLAG_AF = 4;
  localparam int FLAG_ZF = 6;
  localparam int FLAG_SF = 7;
  localparam int FLAG_TF = 8;
  localparam int FLAG_IF = 9;
  localparam int FLAG_DF = 10;
  localparam int FLAG_OF = 11;

  localparam logic [15:0] FLAGS_STORE_MASK =
    (16'd1 << FLAG_CF) | (16'd1 << FLAG_PF) | (16'd1 << FLAG_AF) |
    (16'd1 << FLAG_ZF) | (16'd1 << FLAG_SF) | (16'd1 << FLAG_TF) |
    (16'd1 << FLAG_IF) | (16'd1 << FLAG_DF) | (16'd1 << FLAG_OF);
  localparam logic [15:0] FLAGS_FIXED_ONES = 16'h0002;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAVE    = 2'd1,
    RESTORE = 2'd2
  } ckpt_state_t;

  // Byte addresses (addr[3]=0) map onto word registers 0..3; everything else is a word index.
  function automatic logic [3:0] word_index(input logic [3:0] addr, input logic byte_mode);
    return (byte_mode && !addr[3]) ? {2'b00, addr[1:0]} : addr;
  endfunction

endpackage

// File: rtl/regfile_ckpt_fsm.sv
// Checkpoint sequencer: walks idx over NREG registers plus the FLAGS slot
// for a save or restore sweep and tracks whether the shadow copy is complete.
module regfile_ckpt_fsm
  import zet_regfile_pkg::*;
#(
  parameter int NREG = 16,
  parameter int IW   = $clog2(NREG + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          save_i,
  input  logic          restore_i,
  output ckpt_state_t   state_o,
  output logic [IW-1:0] idx_o,
  output logic          busy_o,
  output logic          ckpt_valid_o
);

  localparam logic [IW-1:0] LAST = IW'(NREG);

  ckpt_state_t   state_q;
  logic [IW-1:0] idx_q;
  logic          busy_q;
  logic          valid_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          idx_q <= '0;
          if (save_i) begin
            state_q <= SAVE;
            busy_q  <= 1'b1;
            valid_q <= 1'b0;
          end else if (restore_i && valid_q) begin
            state_q <= RESTORE;
            busy_q  <= 1'b1;
          end
        end
        SAVE, RESTORE: begin
          if (idx_q == LAST) begin
            state_q <= IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            if (state_q == SAVE) valid_q <= 1'b1;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign state_o      = state_q;
  assign idx_o        = idx_q;
  assign busy_o       = busy_q;
  assign ckpt_valid_o = valid_q;

endmodule

// File: rtl/regfile_ckpt.sv
// 8086-style register file with NRD read ports, FLAGS and a checkpoint/rollback shadow.
// Optional REGFILE_BYPASS_EN forwards the committing write to same-cycle reads.
module regfile_ckpt
  import zet_regfile_pkg::*;
#(
  parameter int              DW     = 16,
  parameter int              NREG   = 16,
  parameter int              NRD    = 3,
  parameter logic [DW-1:0]   CS_RST = 16'hF000,
  parameter logic [DW-1:0]   IP_RST = 16'hFFF0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*4-1:0]    rd_addr,
  input  logic [NRD-1:0]      rd_byte,
  output logic [NRD*DW-1:0]   rd_data,
  input  logic [1:0]          seg_addr,
  output logic [DW-1:0]       seg_data,
  output logic [DW-1:0]       cs,
  input  logic                wr_en,
  input  logic                wr_cond,
  input  logic                wr_word,
  input  logic [3:0]          wr_addr,
  input  logic [DW-1:0]       wr_data,
  input  logic                wr_hi,
  input  logic [DW-1:0]       hi_data,
  input  logic                flags_we,
  input  logic [15:0]         iflags,
  output logic [15:0]         oflags,
  input  logic                ckpt_save,
  input  logic                ckpt_restore,
  output logic                busy,
  output logic                ckpt_valid
);

  localparam int IW = $clog2(NREG + 1);
  localparam int AW = $clog2(NREG);
  localparam logic [IW-1:0] FLAGS_SLOT = IW'(NREG);

  logic [DW-1:0] regs_q   [NREG];
  logic [DW-1:0] regs_d   [NREG];
  logic [DW-1:0] wr_view  [NREG];
  logic [DW-1:0] rd_src   [NREG];
  logic [DW-1:0] shadow_q [NREG+1];
  logic [DW-1:0] shadow_rd;
  logic [15:0]   flags_q, flags_d;

  ckpt_state_t   state;
  logic [IW-1:0] idx;
  logic          pred, wr_commit, hi_commit, flags_commit, wr_is_byte;
  logic [3:0]    wr_tgt;

  regfile_ckpt_fsm #(.NREG(NREG)) u_fsm (
    .clk          (clk),
    .rst          (rst),
    .save_i       (ckpt_save),
    .restore_i    (ckpt_restore),
    .state_o      (state),
    .idx_o        (idx),
    .busy_o       (busy),
    .ckpt_valid_o (ckpt_valid)
  );

  // The predicate always looks at the architectural (pre-edge) word, never the bypass path.
  assign pred         = regs_q[rd_addr[(NRD-1)*4 +: 4]][0];
  assign wr_commit    = wr_en & (~wr_cond | pred) & ~busy;
  assign hi_commit    = wr_hi & ~busy;
  assign flags_commit = flags_we & ~busy;
  assign wr_is_byte   = ~wr_word & ~wr_addr[3];
  assign wr_tgt       = word_index(wr_addr, wr_is_byte);

  // NOTE: every always_comb output gets a full default first so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_view = regs_q;
    if (wr_commit) begin
      if (!wr_is_byte)     wr_view[wr_tgt]       = wr_data;
      else if (wr_addr[2]) wr_view[wr_tgt][15:8] = wr_data[7:0];
      else                 wr_view[wr_tgt][7:0]  = wr_data[7:0];
    end
    // hi_data owns the whole of DX when it collides with a normal write.
    if (hi_commit) wr_view[REG_DX] = hi_data;
  end

  assign shadow_rd = shadow_q[idx];

  always_comb begin
    regs_d  = wr_view;
    flags_d = flags_commit ? (iflags & FLAGS_STORE_MASK) : flags_q;
    if (state == RESTORE) begin
      if (idx == FLAGS_SLOT) flags_d = shadow_rd[15:0] & FLAGS_STORE_MASK;
      else                   regs_d[idx[AW-1:0]] = shadow_rd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= (i == REG_CS) ? CS_RST : (i == REG_IP) ? IP_RST : '0;
      end
      flags_q <= '0;
    end else begin
      regs_q  <= regs_d;
      flags_q <= flags_d;
    end
  end

  // NOTE: the shadow RAM is deliberately not reset; ckpt_valid says whether
  // its contents mean anything, which keeps it mappable onto plain RAM.
  always_ff @(posedge clk) begin
    if (state == SAVE) begin
      shadow_q[idx] <= (idx == FLAGS_SLOT) ? DW'(oflags) : regs_q[idx[AW-1:0]];
    end
  end

`ifdef REGFILE_BYPASS_EN
  assign rd_src = wr_view;
`else
  assign rd_src = regs_q;
`endif

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [3:0]    a;
    logic          bm;
    logic [DW-1:0] w;
    logic [7:0]    b;
    assign a  = rd_addr[p*4 +: 4];
    assign bm = rd_byte[p] & ~a[3];
    assign w  = rd_src[word_index(a, bm)];
    assign b  = a[2] ? w[15:8] : w[7:0];
    assign rd_data[p*DW +: DW] = bm ? {{(DW-8){b[7]}}, b} : w;
  end

  assign seg_data = rd_src[{2'b10, seg_addr}];
  assign cs       = rd_src[REG_CS];
  assign oflags   = flags_q | FLAGS_FIXED_ONES;

endmodule
